// File: rtl/riscv_mem.sv
// Memory-access stage: turns EX load/store instructions into single data-bus requests
// and hands load metadata / ALU results to WB through one output register.
`ifndef LD_NOP
`define LD_FUNCT_W 3
`define LD_NOP     3'd0
`define LD_LB      3'd1
`define LD_LH      3'd2
`define LD_LW      3'd3
`define LD_LBU     3'd4
`define LD_LHU     3'd5
`endif
`ifndef ST_NOP
`define ST_FUNCT_W 2
`define ST_NOP     2'd0
`define ST_SB      2'd1
`define ST_SH      2'd2
`define ST_SW      2'd3
`endif

module riscv_mem #(
    parameter bit CHECK_MISALIGN = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ex_mem_rdy,
    output logic                   ex_mem_ack,
    input  logic [`LD_FUNCT_W-1:0] ex_mem_ld_funct,
    input  logic [`ST_FUNCT_W-1:0] ex_mem_st_funct,
    input  logic [31:0]            ex_mem_data,
    input  logic [31:0]            ex_mem_wdata,
    input  logic [4:0]             ex_mem_rsd,
    output logic                   data_bif_req,
    input  logic                   data_bif_rdy,
    output logic                   data_bif_we,
    output logic [31:0]            data_bif_addr,
    output logic [31:0]            data_bif_wdata,
    output logic [3:0]             data_bif_wmask,
    output logic                   mem_wb_rdy,
    input  logic                   mem_wb_ack,
    output logic [`LD_FUNCT_W-1:0] mem_wb_funct,
    output logic [31:0]            mem_wb_data,
    output logic [4:0]             mem_wb_rsd,
    output logic                   mem_misalign
);
    typedef enum logic {IDLE, REQ} state_t;

    state_t                   state_q, state_d;
    logic                     req_q, req_d, we_q, we_d;
    logic [31:0]              addr_q, addr_d, wdata_q, wdata_d;
    logic [3:0]               wmask_q, wmask_d;
    logic                     wb_rdy_q, wb_rdy_d;
    logic [`LD_FUNCT_W-1:0]   funct_q, funct_d, pend_funct_q, pend_funct_d;
    logic [31:0]              data_q, data_d, pend_addr_q, pend_addr_d;
    logic [4:0]               rsd_q, rsd_d, pend_rsd_q, pend_rsd_d;
    logic                     misalign_q, misalign_d;

    logic        ld_op, st_op, is_half, is_word, bad_align, drain;
    logic [1:0]  lane;
    logic [31:0] lane_wdata;
    logic [3:0]  lane_mask;

    always_comb begin
        ld_op     = (ex_mem_ld_funct != `LD_NOP);
        st_op     = (ex_mem_st_funct != `ST_NOP);
        lane      = ex_mem_data[1:0];
        is_half   = (ex_mem_ld_funct == `LD_LH) || (ex_mem_ld_funct == `LD_LHU) ||
                    (ex_mem_st_funct == `ST_SH);
        is_word   = (ex_mem_ld_funct == `LD_LW) || (ex_mem_st_funct == `ST_SW);
        bad_align = CHECK_MISALIGN && ((is_half && lane[0]) || (is_word && (lane != 2'b00)));
        drain     = !wb_rdy_q || mem_wb_ack;
        ex_mem_ack = ex_mem_rdy && (state_q == IDLE) && drain;

        // Store data is replicated across lanes so the mask alone selects the bytes.
        lane_wdata = 32'h0;
        lane_mask  = 4'b0000;
        case (ex_mem_st_funct)
            `ST_SB: begin
                lane_wdata = {4{ex_mem_wdata[7:0]}};
                lane_mask  = 4'b0001 << lane;
            end
            `ST_SH: begin
                lane_wdata = {2{ex_mem_wdata[15:0]}};
                lane_mask  = 4'b0011 << lane;
            end
            `ST_SW: begin
                lane_wdata = ex_mem_wdata;
                lane_mask  = 4'b1111;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        req_d        = req_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wmask_d      = wmask_q;
        wb_rdy_d     = wb_rdy_q;
        funct_d      = funct_q;
        data_d       = data_q;
        rsd_d        = rsd_q;
        pend_funct_d = pend_funct_q;
        pend_addr_d  = pend_addr_q;
        pend_rsd_d   = pend_rsd_q;
        misalign_d   = 1'b0;

        if (wb_rdy_q && mem_wb_ack)
            wb_rdy_d = 1'b0;

        if (state_q == IDLE) begin
            if (ex_mem_ack) begin
                if (!ld_op && !st_op) begin
                    wb_rdy_d = 1'b1;
                    funct_d  = `LD_NOP;
                    data_d   = ex_mem_data;
                    rsd_d    = ex_mem_rsd;
                end else if (bad_align) begin
                    wb_rdy_d   = 1'b1;
                    funct_d    = `LD_NOP;
                    data_d     = ex_mem_data;
                    rsd_d      = 5'd0;
                    misalign_d = 1'b1;
                end else begin
                    state_d      = REQ;
                    req_d        = 1'b1;
                    we_d         = st_op;
                    addr_d       = {ex_mem_data[31:2], 2'b00};
                    wdata_d      = lane_wdata;
                    wmask_d      = lane_mask;
                    pend_funct_d = ex_mem_ld_funct;
                    pend_addr_d  = ld_op ? ex_mem_data : 32'h0;
                    pend_rsd_d   = ld_op ? ex_mem_rsd : 5'd0;
                    wb_rdy_d     = 1'b0;
                end
            end
        end else if (data_bif_rdy) begin
            // Output register is known empty here, so the result lands without waiting on WB.
            state_d  = IDLE;
            req_d    = 1'b0;
            we_d     = 1'b0;
            wmask_d  = 4'b0000;
            wb_rdy_d = 1'b1;
            funct_d  = pend_funct_q;
            data_d   = pend_addr_q;
            rsd_d    = pend_rsd_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            req_q        <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= 32'h0;
            wdata_q      <= 32'h0;
            wmask_q      <= 4'b0000;
            wb_rdy_q     <= 1'b0;
            funct_q      <= `LD_NOP;
            data_q       <= 32'h0;
            rsd_q        <= 5'd0;
            pend_funct_q <= `LD_NOP;
            pend_addr_q  <= 32'h0;
            pend_rsd_q   <= 5'd0;
            misalign_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wmask_q      <= wmask_d;
            wb_rdy_q     <= wb_rdy_d;
            funct_q      <= funct_d;
            data_q       <= data_d;
            rsd_q        <= rsd_d;
            pend_funct_q <= pend_funct_d;
            pend_addr_q  <= pend_addr_d;
            pend_rsd_q   <= pend_rsd_d;
            misalign_q   <= misalign_d;
        end
    end

    assign data_bif_req   = req_q;
    assign data_bif_we    = we_q;
    assign data_bif_addr  = addr_q;
    assign data_bif_wdata = wdata_q;
    assign data_bif_wmask = wmask_q;
    assign mem_wb_rdy     = wb_rdy_q;
    assign mem_wb_funct   = funct_q;
    assign mem_wb_data    = data_q;
    assign mem_wb_rsd     = rsd_q;
    assign mem_misalign   = misalign_q;
endmodule
